// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - slave codes, address bases and arbiter states shared by the AXI bridge arbiters
package axi_arb_pkg;

  localparam logic [2:0] SLV_NONE  = 3'b000;
  localparam logic [2:0] SLV_ROM   = 3'b001;
  localparam logic [2:0] SLV_IM    = 3'b010;
  localparam logic [2:0] SLV_DM    = 3'b011;
  localparam logic [2:0] SLV_SCTRL = 3'b100;
  localparam logic [2:0] SLV_WDT   = 3'b101;
  localparam logic [2:0] SLV_DRAM  = 3'b110;
  localparam logic [2:0] SLV_DEF   = 3'b111;

  localparam logic [15:0] BASE_ROM   = 16'h0000;
  localparam logic [15:0] BASE_IM    = 16'h0001;
  localparam logic [15:0] BASE_DM    = 16'h0002;
  localparam logic [15:0] BASE_SCTRL = 16'h1000;
  localparam logic [15:0] BASE_WDT   = 16'h1001;
  localparam logic [7:0]  BASE_DRAM  = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/axi_addr_decode.sv
// rtl/axi_addr_decode.sv - maps an AXI address to a 3-bit slave code; write mode sends ROM to the default slave
module axi_addr_decode
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              write_mode,
  output logic [2:0]        slave
);

  // Only the 64 KiB region index takes part in decoding.
  logic unused_lo;
  assign unused_lo = ^addr[15:0];

  always_comb begin
    slave = SLV_DEF;
    if (addr[31:24] == BASE_DRAM) begin
      slave = SLV_DRAM;
    end else begin
      case (addr[31:16])
        BASE_ROM:   slave = write_mode ? SLV_DEF : SLV_ROM;
        BASE_IM:    slave = SLV_IM;
        BASE_DM:    slave = SLV_DM;
        BASE_SCTRL: slave = SLV_SCTRL;
        BASE_WDT:   slave = SLV_WDT;
        default:    slave = SLV_DEF;
      endcase
    end
  end

endmodule

// File: rtl/write_arbiter.sv
// rtl/write_arbiter.sv - two-master AXI write-path arbiter holding one AW/W/B transaction at a time
module write_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ADDR_W-1:0] AWADDR_M0,
  input  logic [ADDR_W-1:0] AWADDR_M1,
  input  logic [LEN_W-1:0]  AWLEN_M0,
  input  logic [LEN_W-1:0]  AWLEN_M1,
  input  logic              AWVALID_M0,
  input  logic              AWVALID_M1,
  input  logic              AWREADY_M0,
  input  logic              AWREADY_M1,
  input  logic              WVALID_M0,
  input  logic              WVALID_M1,
  input  logic              WREADY_M0,
  input  logic              WREADY_M1,
  input  logic              WLAST_M0,
  input  logic              WLAST_M1,
  input  logic              BVALID_M0,
  input  logic              BVALID_M1,
  input  logic              BREADY_M0,
  input  logic              BREADY_M1,
  output logic [3:0]        AW_arbiter,
  output logic [1:0]        cs,
  output logic [LEN_W-1:0]  beat_cnt,
  output logic              len_err
);

  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};

  arb_state_e        state;
  logic              owner;
  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  len_reg;

  logic              any_req;
  logic              win_m1;
  logic              win_hs;
  logic [ADDR_W-1:0] live_addr;
  logic [LEN_W-1:0]  live_len;
  logic [2:0]        live_slv;
  logic [2:0]        reg_slv;
  logic              own_aw_hs;
  logic              own_w_hs;
  logic              own_wlast;
  logic              own_b_hs;

  // Fixed priority: M1 wins whenever it is requesting.
  assign any_req   = AWVALID_M0 | AWVALID_M1;
  assign win_m1    = AWVALID_M1;
  assign win_hs    = win_m1 ? AWREADY_M1 : AWREADY_M0;
  assign live_addr = win_m1 ? AWADDR_M1 : AWADDR_M0;
  assign live_len  = win_m1 ? AWLEN_M1 : AWLEN_M0;

  assign own_aw_hs = owner ? (AWVALID_M1 & AWREADY_M1) : (AWVALID_M0 & AWREADY_M0);
  assign own_w_hs  = owner ? (WVALID_M1 & WREADY_M1) : (WVALID_M0 & WREADY_M0);
  assign own_wlast = owner ? WLAST_M1 : WLAST_M0;
  assign own_b_hs  = owner ? (BVALID_M1 & BREADY_M1) : (BVALID_M0 & BREADY_M0);

  axi_addr_decode #(.ADDR_W(ADDR_W)) u_dec_live (
    .addr       (live_addr),
    .write_mode (1'b1),
    .slave      (live_slv)
  );

  axi_addr_decode #(.ADDR_W(ADDR_W)) u_dec_reg (
    .addr       (addr_reg),
    .write_mode (1'b1),
    .slave      (reg_slv)
  );

  // Grant is combinational in IDLE; afterwards the latched address keeps the route stable through B.
  always_comb begin
    AW_arbiter = {SLV_NONE, 1'b0};
    if (state == ST_IDLE) begin
      if (any_req) AW_arbiter = {live_slv, win_m1};
    end else begin
      AW_arbiter = {reg_slv, owner};
    end
  end

  assign cs = state;

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      state    <= ST_IDLE;
      owner    <= 1'b0;
      addr_reg <= '0;
      len_reg  <= '0;
      beat_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner    <= win_m1;
            addr_reg <= live_addr;
            len_reg  <= live_len;
            beat_cnt <= '0;
            len_err  <= 1'b0;
            state    <= win_hs ? ST_W : ST_AW;
          end
        end
        ST_AW: begin
          if (own_aw_hs) state <= ST_W;
        end
        ST_W: begin
          if (own_w_hs) begin
            if (beat_cnt != CNT_MAX) beat_cnt <= beat_cnt + CNT_ONE;
            // beat_cnt still holds the count before this beat, so the expected last beat sees len_reg.
            if (own_wlast) begin
              state <= ST_B;
              if (beat_cnt != len_reg) len_err <= 1'b1;
            end else if (beat_cnt == len_reg) begin
              len_err <= 1'b1;
            end
          end
        end
        ST_B: begin
          if (own_b_hs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_arbiter.sv
// tb/tb_write_arbiter.sv - scoreboard bench for write_arbiter with randomized transactions
module tb_write_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [31:0] AWADDR_M0, AWADDR_M1;
  logic [3:0]  AWLEN_M0, AWLEN_M1;
  logic        AWVALID_M0, AWVALID_M1, AWREADY_M0, AWREADY_M1;
  logic        WVALID_M0, WVALID_M1, WREADY_M0, WREADY_M1, WLAST_M0, WLAST_M1;
  logic        BVALID_M0, BVALID_M1, BREADY_M0, BREADY_M1;
  logic [3:0]  AW_arbiter;
  logic [1:0]  cs;
  logic [3:0]  beat_cnt;
  logic        len_err;

  write_arbiter #(.ADDR_W(32), .LEN_W(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR_M0(AWADDR_M0), .AWADDR_M1(AWADDR_M1),
    .AWLEN_M0(AWLEN_M0), .AWLEN_M1(AWLEN_M1),
    .AWVALID_M0(AWVALID_M0), .AWVALID_M1(AWVALID_M1),
    .AWREADY_M0(AWREADY_M0), .AWREADY_M1(AWREADY_M1),
    .WVALID_M0(WVALID_M0), .WVALID_M1(WVALID_M1),
    .WREADY_M0(WREADY_M0), .WREADY_M1(WREADY_M1),
    .WLAST_M0(WLAST_M0), .WLAST_M1(WLAST_M1),
    .BVALID_M0(BVALID_M0), .BVALID_M1(BVALID_M1),
    .BREADY_M0(BREADY_M0), .BREADY_M1(BREADY_M1),
    .AW_arbiter(AW_arbiter), .cs(cs), .beat_cnt(beat_cnt), .len_err(len_err)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [3:0] arb;
    logic [3:0] cnt;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  function automatic logic [2:0] slave_of(input logic [31:0] a);
    if (a[31:24] == 8'h20) return 3'd6;
    case (a[31:16])
      16'h0001: return 3'd2;
      16'h0002: return 3'd3;
      16'h1000: return 3'd4;
      16'h1001: return 3'd5;
      default:  return 3'd7;
    endcase
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] bases [8];
    int k;
    bases = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h1000_0000,
              32'h1001_0000, 32'h2000_0000, 32'h3000_0000, 32'h0003_0000};
    k = $urandom_range(0, 7);
    if (k == 5) return bases[k] | ($urandom & 32'h00ff_ffff);
    return bases[k] | ($urandom & 32'h0000_ffff);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit m, input logic [31:0] a, input int len, input int n);
    exp_t e;
    e.arb = {slave_of(a), m};
    e.cnt = (n > 15) ? 4'd15 : 4'(n);
    e.err = (n != len + 1);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_aw(input bit m, input bit v, input logic [31:0] a, input logic [3:0] l);
    if (m) begin AWVALID_M1 = v; AWADDR_M1 = a; AWLEN_M1 = l; end
    else   begin AWVALID_M0 = v; AWADDR_M0 = a; AWLEN_M0 = l; end
  endtask

  task automatic set_awvalid(input bit m, input bit v);
    if (m) AWVALID_M1 = v; else AWVALID_M0 = v;
  endtask

  task automatic set_awready(input bit m, input bit v);
    if (m) AWREADY_M1 = v; else AWREADY_M0 = v;
  endtask

  task automatic set_w(input bit m, input bit v, input bit r, input bit l);
    if (m) begin WVALID_M1 = v; WREADY_M1 = r; WLAST_M1 = l; end
    else   begin WVALID_M0 = v; WREADY_M0 = r; WLAST_M0 = l; end
  endtask

  task automatic set_b(input bit m, input bit v, input bit r);
    if (m) begin BVALID_M1 = v; BREADY_M1 = r; end
    else   begin BVALID_M0 = v; BREADY_M0 = r; end
  endtask

  // Owner W activity while the address is still pending must be ignored.
  task automatic aw_phase(input bit m, input int dly);
    repeat (dly) begin
      set_awready(m, 1'b0);
      set_w(m, 1'($urandom % 2), 1'($urandom % 2), 1'b0);
      tick();
    end
    set_w(m, 1'b0, 1'b0, 1'b0);
    set_awready(m, 1'b1);
    tick();
    set_awready(m, 1'b0);
    set_awvalid(m, 1'b0);
  endtask

  task automatic beats(input bit m, input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      int g;
      g = $urandom_range(0, maxgap);
      repeat (g) begin
        set_w(m, 1'($urandom % 2), 1'b0, 1'($urandom % 2));
        set_w(!m, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
        tick();
      end
      set_w(m, 1'b1, 1'b1, i == n - 1);
      set_w(!m, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
      tick();
    end
    set_w(1'b0, 1'b0, 1'b0, 1'b0);
    set_w(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic finish_b(input bit m, input int dly);
    repeat (dly) begin
      set_b(m, 1'($urandom % 2), 1'b0);
      tick();
    end
    set_b(m, 1'b1, 1'b1);
    tick();
    set_b(m, 1'b0, 1'b0);
  endtask

  task automatic serve(input bit m, input logic [31:0] a, input int len, input int n,
                       input int awdly, input int gap, input int bdly);
    push_exp(m, a, len, n);
    aw_phase(m, awdly);
    beats(m, n, gap);
    finish_b(m, bdly);
  endtask

  // Monitor: every completed B handshake retires one expected transaction.
  always @(negedge ACLK) begin
    if (!ARESETn && cs == 2'd3 &&
        (AW_arbiter[0] ? (BVALID_M1 & BREADY_M1) : (BVALID_M0 & BREADY_M0))) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected: response routed to %b, none expected", AW_arbiter);
      end else begin
        mon_e = sb.pop_front();
        chk("b_arbiter", AW_arbiter, mon_e.arb);
        chk("b_beat_cnt", beat_cnt, mon_e.cnt);
        chk("b_len_err", len_err, mon_e.err);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a0, a1;
    int l0, l1, n0, n1, mode;

    ARESETn = 1'b1;
    set_aw(1'b0, 1'b0, 32'h0, 4'h0); set_aw(1'b1, 1'b0, 32'h0, 4'h0);
    set_awready(1'b0, 1'b0); set_awready(1'b1, 1'b0);
    set_w(1'b0, 1'b0, 1'b0, 1'b0); set_w(1'b1, 1'b0, 1'b0, 1'b0);
    set_b(1'b0, 1'b0, 1'b0); set_b(1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_cs", cs, 0);
    chk("rst_arbiter", AW_arbiter, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_len_err", len_err, 0);
    tick();
    ARESETn = 1'b0;
    tick();

    // Single M1 burst to DM, AWREADY in the grant cycle
    set_aw(1'b1, 1'b1, 32'h0002_0010, 4'd3);
    set_awready(1'b1, 1'b1);
    push_exp(1'b1, 32'h0002_0010, 3, 4);
    @(negedge ACLK);
    chk("t1_grant", AW_arbiter, 4'b0111);
    chk("t1_idle", cs, 0);
    tick();
    set_awready(1'b1, 1'b0);
    set_awvalid(1'b1, 1'b0);
    @(negedge ACLK);
    chk("t1_cs_w", cs, 2);
    beats(1'b1, 4, 0);
    @(negedge ACLK);
    chk("t1_cs_b", cs, 3);
    chk("t1_beats", beat_cnt, 4);
    chk("t1_len_err", len_err, 0);
    finish_b(1'b1, 0);
    @(negedge ACLK);
    chk("t1_back_idle", cs, 0);
    chk("t1_no_grant", AW_arbiter, 0);

    // Simultaneous requests: M1 first, then the waiting M0
    tick();
    set_aw(1'b0, 1'b1, 32'h1000_0000, 4'd1);
    set_aw(1'b1, 1'b1, 32'h2000_0040, 4'd0);
    @(negedge ACLK);
    chk("t2_m1_grant", AW_arbiter, 4'b1101);
    serve(1'b1, 32'h2000_0040, 0, 1, 1, 1, 1);
    @(negedge ACLK);
    chk("t2_m0_grant", AW_arbiter, 4'b1000);
    serve(1'b0, 32'h1000_0000, 1, 2, 0, 1, 0);

    // ROM write goes to the default slave
    tick();
    set_aw(1'b0, 1'b1, 32'h0000_0100, 4'd0);
    @(negedge ACLK);
    chk("t3_rom_grant", AW_arbiter, 4'b1110);
    serve(1'b0, 32'h0000_0100, 0, 1, 2, 0, 1);

    // Early WLAST
    tick();
    set_aw(1'b1, 1'b1, 32'h0001_0004, 4'd1);
    push_exp(1'b1, 32'h0001_0004, 1, 1);
    aw_phase(1'b1, 0);
    beats(1'b1, 1, 0);
    @(negedge ACLK);
    chk("t4a_cs_b", cs, 3);
    chk("t4a_len_err", len_err, 1);
    finish_b(1'b1, 0);

    // Missing WLAST on the expected last beat
    tick();
    set_aw(1'b0, 1'b1, 32'h1001_0000, 4'd0);
    push_exp(1'b0, 32'h1001_0000, 0, 2);
    aw_phase(1'b0, 0);
    set_w(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_w(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge ACLK);
    chk("t4b_cs_w", cs, 2);
    chk("t4b_len_err", len_err, 1);
    chk("t4b_beats", beat_cnt, 1);
    set_w(1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    set_w(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge ACLK);
    chk("t4b_cs_b", cs, 3);
    finish_b(1'b0, 0);

    // Delayed AWREADY with the master address changing, plus non-owner W traffic
    tick();
    set_aw(1'b0, 1'b1, 32'h0001_0000, 4'd2);
    push_exp(1'b0, 32'h0001_0000, 2, 3);
    tick();
    AWADDR_M0 = 32'h1001_0000;
    set_w(1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge ACLK);
    chk("t5_cs_aw", cs, 1);
    chk("t5_arb_held", AW_arbiter, 4'b0100);
    tick();
    set_w(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_awready(1'b0, 1'b1);
    tick();
    set_awready(1'b0, 1'b0);
    set_awvalid(1'b0, 1'b0);
    set_w(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    set_w(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge ACLK);
    chk("t5_cs_w", cs, 2);
    chk("t5_nonowner_ignored", beat_cnt, 0);
    beats(1'b0, 3, 1);
    finish_b(1'b0, 1);

    // Asynchronous reset in the middle of a burst
    tick();
    set_aw(1'b1, 1'b1, 32'h1001_0000, 4'd0);
    set_awready(1'b1, 1'b1);
    tick();
    set_awready(1'b1, 1'b0);
    set_awvalid(1'b1, 1'b0);
    set_w(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    set_w(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge ACLK);
    chk("t6_pre_beats", beat_cnt, 2);
    chk("t6_pre_err", len_err, 1);
    #1 ARESETn = 1'b1;
    #1;
    chk("t6_cs", cs, 0);
    chk("t6_beats", beat_cnt, 0);
    chk("t6_len_err", len_err, 0);
    chk("t6_arbiter", AW_arbiter, 0);
    tick();
    tick();
    ARESETn = 1'b0;
    tick();

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 2);
      a0 = rand_addr();
      a1 = rand_addr();
      l0 = $urandom_range(0, 15);
      l1 = $urandom_range(0, 15);
      n0 = ($urandom % 3 != 0) ? l0 + 1 : $urandom_range(1, 17);
      n1 = ($urandom % 3 != 0) ? l1 + 1 : $urandom_range(1, 17);
      if (mode == 0) begin
        set_aw(1'b0, 1'b1, a0, 4'(l0));
        @(negedge ACLK);
        chk("rnd_m0_grant", AW_arbiter, {slave_of(a0), 1'b0});
        serve(1'b0, a0, l0, n0, $urandom_range(0, 3), 2, $urandom_range(0, 2));
      end else if (mode == 1) begin
        set_aw(1'b1, 1'b1, a1, 4'(l1));
        @(negedge ACLK);
        chk("rnd_m1_grant", AW_arbiter, {slave_of(a1), 1'b1});
        serve(1'b1, a1, l1, n1, $urandom_range(0, 3), 2, $urandom_range(0, 2));
      end else begin
        set_aw(1'b0, 1'b1, a0, 4'(l0));
        set_aw(1'b1, 1'b1, a1, 4'(l1));
        @(negedge ACLK);
        chk("rnd_both_m1_grant", AW_arbiter, {slave_of(a1), 1'b1});
        serve(1'b1, a1, l1, n1, $urandom_range(0, 3), 2, $urandom_range(0, 2));
        @(negedge ACLK);
        chk("rnd_both_m0_grant", AW_arbiter, {slave_of(a0), 1'b0});
        serve(1'b0, a0, l0, n0, $urandom_range(0, 3), 2, $urandom_range(0, 2));
      end
      tick();
    end

    repeat (5) tick();
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
